version_report_seq: RTL and testbench

- Build-identification reporter. On request it serialises the version_pkg constants into a fixed 14-byte framed packet on a byte-wide valid/ready stream.
- The stream typically feeds the UART TX path.
- Two independent requesters share the single output stream, for example the host command parser and a debug pushbutton strobe.
- A round-robin arbiter with pending-request latches sequences them one frame at a time.

---
 rtl/version_report_seq.sv | 188 ++++++++++++++++++
 tb/tb_version_report_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/version_report_seq.sv
// Build-identification reporter: serialises version constants into a 14-byte framed stream.
// Optional stall timeout is enabled by defining VERSION_REPORT_TIMEOUT_EN.
module version_report_seq #(
  parameter logic [7:0]  C_HEADER         = 8'hA5,
`ifdef VERSION_REPORT_TIMEOUT_EN
  parameter int unsigned C_TIMEOUT_CYCLES = 1024,
`endif
  parameter logic [7:0]  C_MAJOR          = 8'h00,
  parameter logic [7:0]  C_MINOR          = 8'h00,
  parameter logic [7:0]  C_PATCH          = 8'h00,
  parameter logic [7:0]  C_BUILD          = 8'h40,
  parameter logic [15:0] C_YEAR           = 16'h2025,
  parameter logic [7:0]  C_MONTH          = 8'h11,
  parameter logic [7:0]  C_DAY            = 8'h08,
  parameter logic [7:0]  C_HOUR           = 8'h15,
  parameter logic [7:0]  C_MINUTE         = 8'h03,
  parameter logic [7:0]  C_SECOND         = 8'h23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a_i,
  input  logic       req_b_i,
  output logic [7:0] m_tdata_o,
  output logic       m_tvalid_o,
  input  logic       m_tready_i,
  output logic       m_tlast_o,
  output logic       busy_o,
  output logic       src_o,
  output logic       done_o,
  output logic       abort_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;
  localparam logic [3:0] LastIdx = 4'd13;

  logic [0:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       pend_a_q, pend_a_d;
  logic       pend_b_q, pend_b_d;
  logic       last_b_q, last_b_d;
  logic       src_q, src_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] byte_sel;
  logic       xfer, grant_a, grant_b;

`ifdef VERSION_REPORT_TIMEOUT_EN
  localparam logic [15:0] StallLim = 16'(C_TIMEOUT_CYCLES - 1);
  logic [15:0] stall_q, stall_d;
  logic        abort_q, abort_d;
`endif

  assign xfer    = valid_q & m_tready_i;
  // B wins when A is idle, or when both are pending and A was served last.
  assign grant_b = pend_b_q & (~pend_a_q | ~last_b_q);
  assign grant_a = pend_a_q & ~grant_b;

  always_comb begin
    byte_sel = 8'h00;
    unique case (idx_q)
      4'd0:    byte_sel = C_HEADER;
      4'd1:    byte_sel = {7'b0, src_q};
      4'd2:    byte_sel = C_MAJOR;
      4'd3:    byte_sel = C_MINOR;
      4'd4:    byte_sel = C_PATCH;
      4'd5:    byte_sel = C_BUILD;
      4'd6:    byte_sel = C_YEAR[15:8];
      4'd7:    byte_sel = C_YEAR[7:0];
      4'd8:    byte_sel = C_MONTH;
      4'd9:    byte_sel = C_DAY;
      4'd10:   byte_sel = C_HOUR;
      4'd11:   byte_sel = C_MINUTE;
      4'd12:   byte_sel = C_SECOND;
      4'd13:   byte_sel = csum_q;
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    last_b_d = last_b_q;
    src_d    = src_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    csum_d   = csum_q;
`ifdef VERSION_REPORT_TIMEOUT_EN
    stall_d  = stall_q;
    abort_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pend_a_q | pend_b_q) begin
          state_d  = StSend;
          idx_d    = 4'd0;
          valid_d  = 1'b1;
          csum_d   = 8'h00;
          src_d    = grant_b;
          last_b_d = grant_b;
          pend_a_d = pend_a_q & ~grant_a;
          pend_b_d = pend_b_q & ~grant_b;
`ifdef VERSION_REPORT_TIMEOUT_EN
          stall_d  = 16'd0;
`endif
        end
      end
      default: begin
        if (xfer) begin
          csum_d = csum_q ^ byte_sel;
`ifdef VERSION_REPORT_TIMEOUT_EN
          stall_d = 16'd0;
`endif
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
`ifdef VERSION_REPORT_TIMEOUT_EN
        else if (valid_q) begin
          if (stall_q == StallLim) begin
            state_d = StIdle;
            valid_d = 1'b0;
            abort_d = 1'b1;
            stall_d = 16'd0;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
`endif
      end
    endcase
    // A new request always re-arms its latch, even on the edge that grants it.
    pend_a_d = pend_a_d | req_a_i;
    pend_b_d = pend_b_d | req_b_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 4'd0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      last_b_q <= 1'b1;
      src_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      csum_q   <= 8'h00;
`ifdef VERSION_REPORT_TIMEOUT_EN
      stall_q  <= 16'd0;
      abort_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      last_b_q <= last_b_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      csum_q   <= csum_d;
`ifdef VERSION_REPORT_TIMEOUT_EN
      stall_q  <= stall_d;
      abort_q  <= abort_d;
`endif
    end
  end

  assign m_tdata_o  = valid_q ? byte_sel : 8'h00;
  assign m_tvalid_o = valid_q;
  assign m_tlast_o  = valid_q & (idx_q == LastIdx);
  assign busy_o     = (state_q == StSend);
  assign src_o      = src_q;
  assign done_o     = done_q;
`ifdef VERSION_REPORT_TIMEOUT_EN
  assign abort_o    = abort_q;
`else
  assign abort_o    = 1'b0;
`endif

endmodule

// File: tb/tb_version_report_seq.sv
// Scoreboard bench for version_report_seq: expected bytes queued at request time,
// checked by an independent stream monitor.
module tb_version_report_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a_i = 1'b0;
  logic       req_b_i = 1'b0;
  logic       m_tready_i = 1'b0;
  logic [7:0] m_tdata_o;
  logic       m_tvalid_o, m_tlast_o, busy_o, src_o, done_o, abort_o;

`ifdef VERSION_REPORT_TIMEOUT_EN
  version_report_seq #(.C_TIMEOUT_CYCLES(8)) u_dut (
`else
  version_report_seq u_dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .req_a_i    (req_a_i),
    .req_b_i    (req_b_i),
    .m_tdata_o  (m_tdata_o),
    .m_tvalid_o (m_tvalid_o),
    .m_tready_i (m_tready_i),
    .m_tlast_o  (m_tlast_o),
    .busy_o     (busy_o),
    .src_o      (src_o),
    .done_o     (done_o),
    .abort_o    (abort_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int xfer_cnt = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  logic [7:0] frame_a[14];
  logic [7:0] frame_b[14];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input bit src, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == 13), (src ? frame_b[i] : frame_a[i])});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a_i = 1'b0;
    req_b_i = 1'b0;
    m_tready_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tdata"}, m_tdata_o, 0);
    chk({tag, "_tvalid"}, m_tvalid_o, 0);
    chk({tag, "_tlast"}, m_tlast_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_src"}, src_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_abort"}, abort_o, 0);
  endtask

  task automatic wait_done_pulse(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < budget);
    chk(name, done_o, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tvalid_o && n < budget);
    chk(name, m_tvalid_o, 1);
  endtask

  // Stream monitor: pops the scoreboard on every transfer and checks stall stability.
  logic       prev_stall = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8:0] exp_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall && !abort_o) begin
        chk("stall_valid", m_tvalid_o, 1);
        chk("stall_data", m_tdata_o, prev_data);
        chk("stall_last", m_tlast_o, prev_last);
      end
      if (m_tvalid_o && m_tready_i) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %02h, expected no transfer", m_tdata_o);
        end else begin
          exp_e = exp_q.pop_front();
          chk("byte_last_data", {m_tlast_o, m_tdata_o}, exp_e);
        end
      end
      if (done_o) begin
        done_cnt++;
        chk("done_width", prev_done, 0);
      end
      if (abort_o) abort_cnt++;
      prev_stall = m_tvalid_o & ~m_tready_i;
      prev_data  = m_tdata_o;
      prev_last  = m_tlast_o;
      prev_done  = done_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    int d0, x0, c0, a0;
    frame_a = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h20,
                8'h25, 8'h11, 8'h08, 8'h15, 8'h03, 8'h23, 8'hCC};
    frame_b = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h20,
                8'h25, 8'h11, 8'h08, 8'h15, 8'h03, 8'h23, 8'hCD};

    // Single A request, always ready.
    do_reset();
    m_tready_i = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");
    push_frame(1'b0, 14);
    d0 = done_cnt;
    req_a_i = 1'b1;
    tick();
    req_a_i = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", m_tvalid_o, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", m_tvalid_o, 1);
    chk("lat_cycle2_data", m_tdata_o, 8'hA5);
    chk("a_busy", busy_o, 1);
    chk("a_src", src_o, 0);
    wait_done_pulse(40, "a_done");
    chk("a_done_valid", m_tvalid_o, 0);
    chk("a_done_src", src_o, 0);
    tick();
    tick();
    chk("a_done_count", done_cnt - d0, 1);
    chk("a_queue_empty", exp_q.size(), 0);

    // Simultaneous A+B after reset: A first, one idle cycle, then B.
    do_reset();
    m_tready_i = 1'b1;
    push_frame(1'b0, 14);
    push_frame(1'b1, 14);
    req_a_i = 1'b1;
    req_b_i = 1'b1;
    tick();
    req_a_i = 1'b0;
    req_b_i = 1'b0;
    wait_valid(10, "ab_first_valid");
    chk("ab_first_src", src_o, 0);
    wait_done_pulse(40, "ab_first_done");
    chk("ab_gap_valid", m_tvalid_o, 0);
    chk("ab_gap_busy", busy_o, 0);
    @(negedge clk);
    chk("ab_second_valid", m_tvalid_o, 1);
    chk("ab_second_src", src_o, 1);
    wait_done_pulse(40, "ab_second_done");
    tick();
    chk("ab_queue_empty", exp_q.size(), 0);

    // Random back-pressure.
    do_reset();
    push_frame(1'b0, 14);
    d0 = done_cnt;
    x0 = xfer_cnt;
    req_a_i = 1'b1;
    for (int i = 0; i < 600 && done_cnt < d0 + 1; i++) begin
      m_tready_i = 1'($urandom_range(0, 1));
      tick();
      req_a_i = 1'b0;
    end
    m_tready_i = 1'b1;
    tick();
    chk("rand_done", done_cnt - d0, 1);
    chk("rand_xfers", xfer_cnt - x0, 14);
    chk("rand_queue_empty", exp_q.size(), 0);

    // Repeated B requests merge; one during its own frame re-arms once.
    do_reset();
    m_tready_i = 1'b1;
    push_frame(1'b0, 14);
    push_frame(1'b1, 14);
    push_frame(1'b1, 14);
    d0 = done_cnt;
    req_a_i = 1'b1;
    tick();
    req_a_i = 1'b0;
    wait_valid(10, "merge_a_valid");
    tick();
    for (int i = 0; i < 3; i++) begin
      req_b_i = 1'b1;
      tick();
      req_b_i = 1'b0;
      tick();
    end
    for (int i = 0; i < 40 && !(m_tvalid_o && src_o); i++) @(negedge clk);
    chk("merge_b_started", {m_tvalid_o, src_o}, 2'b11);
    tick();
    tick();
    req_b_i = 1'b1;
    tick();
    req_b_i = 1'b0;
    for (int i = 0; i < 100 && done_cnt < d0 + 3; i++) tick();
    repeat (30) tick();
    chk("merge_frames", done_cnt - d0, 3);
    chk("merge_idle", busy_o, 0);
    chk("merge_queue_empty", exp_q.size(), 0);

    // Reset at index 7 drops the frame and clears pending requests.
    do_reset();
    m_tready_i = 1'b1;
    push_frame(1'b0, 7);
    d0 = done_cnt;
    req_a_i = 1'b1;
    tick();
    req_a_i = 1'b0;
    wait_valid(10, "mid_valid");
    req_b_i = 1'b1;
    tick();
    req_b_i = 1'b0;
    repeat (6) tick();
    chk("mid_index7_data", m_tdata_o, 8'h25);
    rst = 1'b1;
    m_tready_i = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("mid");
    chk("mid_queue_empty", exp_q.size(), 0);
    repeat (20) tick();
    chk("mid_pend_cleared", busy_o, 0);
    chk("mid_no_done", done_cnt - d0, 0);
    push_frame(1'b0, 14);
    m_tready_i = 1'b1;
    req_a_i = 1'b1;
    tick();
    req_a_i = 1'b0;
    wait_done_pulse(40, "mid_clean_done");
    tick();
    chk("mid_clean_queue_empty", exp_q.size(), 0);

`ifdef VERSION_REPORT_TIMEOUT_EN
    // Stall from index 3 aborts after 8 cycles; pending B then runs.
    do_reset();
    m_tready_i = 1'b1;
    push_frame(1'b0, 3);
    push_frame(1'b1, 14);
    d0 = done_cnt;
    a0 = abort_cnt;
    req_a_i = 1'b1;
    tick();
    req_a_i = 1'b0;
    wait_valid(10, "to_valid");
    repeat (3) tick();
    m_tready_i = 1'b0;
    c0 = cyc;
    req_b_i = 1'b1;
    tick();
    req_b_i = 1'b0;
    for (int i = 0; i < 30 && !abort_o; i++) @(negedge clk);
    chk("to_abort", abort_o, 1);
    chk("to_abort_delay", cyc - c0, 8);
    chk("to_abort_valid", m_tvalid_o, 0);
    chk("to_abort_done", done_o, 0);
    m_tready_i = 1'b1;
    wait_done_pulse(40, "to_b_done");
    chk("to_b_src", src_o, 1);
    tick();
    chk("to_done_count", done_cnt - d0, 1);
    chk("to_abort_count", abort_cnt - a0, 1);
    chk("to_queue_empty", exp_q.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
